// File: rtl/loader_pkg.sv
// Shared types and acknowledge codes for the UART boot-path program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LEN,
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [7:0] ACK_OK  = 8'hAA;
   localparam logic [7:0] ACK_ERR = 8'h55;

endpackage

// File: rtl/prog_loader.sv
// Program loader: takes a length word then that many payload words from the
// concat stage and writes them to instruction memory from address 0 upward.
//
// state       | meaning
// ST_IDLE     | waiting for start after reset
// ST_WAIT_LEN | armed, next valid word is the length L
// ST_LOAD     | writing payload words at addresses 0..L-1
// ST_DONE     | load complete (or L == 0), ack 0xAA sent on entry
// ST_ERR      | L exceeded memory capacity, ack 0x55 sent on entry
module prog_loader
   import loader_pkg::*;
#(
   parameter int DATAW = 32,
   parameter int ADDRW = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DATAW-1:0] din,
   input  logic             din_valid,
   output logic             imem_we,
   output logic [ADDRW-1:0] imem_addr,
   output logic [DATAW-1:0] imem_wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [DATAW-1:0] checksum,
   output logic             ack_send,
   output logic [7:0]       ack_byte
);

   // Compared against the zero-extended length so no upper bits are lost.
   localparam logic [DATAW:0] MAX_LEN = (DATAW+1)'(1) << ADDRW;

   state_t           state;
   logic [ADDRW:0]   count;
   logic [ADDRW:0]   len_q;
   logic [ADDRW:0]   count_nxt;
   logic             len_oversize;

   assign count_nxt    = count + (ADDRW+1)'(1);
   assign len_oversize = ({1'b0, din} > MAX_LEN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         len_q      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         checksum   <= '0;
         ack_send   <= 1'b0;
         ack_byte   <= 8'h00;
      end else begin
         imem_we  <= 1'b0;
         ack_send <= 1'b0;

         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state    <= ST_WAIT_LEN;
                  count    <= '0;
                  checksum <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end

            ST_WAIT_LEN: begin
               if (din_valid) begin
                  if (din == '0) begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     ack_send <= 1'b1;
                     ack_byte <= ACK_OK;
                  end else if (len_oversize) begin
                     state    <= ST_ERR;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     ack_send <= 1'b1;
                     ack_byte <= ACK_ERR;
                  end else begin
                     state <= ST_LOAD;
                     len_q <= din[ADDRW:0];
                  end
               end
            end

            ST_LOAD: begin
               if (din_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= count[ADDRW-1:0];
                  imem_wdata <= din;
                  checksum   <= checksum ^ din;
                  count      <= count_nxt;
                  if (count_nxt == len_q) begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     ack_send <= 1'b1;
                     ack_byte <= ACK_OK;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: a full-size instance and an ADDRW=4 instance.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;

   logic        start;
   logic [31:0] din;
   logic        din_valid;
   logic        imem_we;
   logic [13:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        busy, done, err, ack_send;
   logic [31:0] checksum;
   logic [7:0]  ack_byte;

   logic        s_start;
   logic [31:0] s_din;
   logic        s_din_valid;
   logic        s_imem_we;
   logic [3:0]  s_imem_addr;
   logic [31:0] s_imem_wdata;
   logic        s_busy, s_done, s_err, s_ack_send;
   logic [31:0] s_checksum;
   logic [7:0]  s_ack_byte;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (imem_we === 1'b1) wr_cnt++;

   prog_loader #(.DATAW(32), .ADDRW(14)) dut (
      .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .checksum(checksum),
      .ack_send(ack_send), .ack_byte(ack_byte)
   );

   prog_loader #(.DATAW(32), .ADDRW(4)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .din(s_din), .din_valid(s_din_valid),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .checksum(s_checksum),
      .ack_send(s_ack_send), .ack_byte(s_ack_byte)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; din = 0; din_valid = 0;
      s_start = 0; s_din = 0; s_din_valid = 0;
      #3;
      n_cmp++;
      if ({imem_we, busy, done, err, ack_send} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 00000", {imem_we, busy, done, err, ack_send});
      end
      n_cmp++;
      if ({imem_addr, imem_wdata, checksum, ack_byte} !== '0) begin
         n_bad++; $display("FAIL reset_data: addr=%h wdata=%h csum=%h ack=%h want all 0",
                           imem_addr, imem_wdata, checksum, ack_byte);
      end
      step(); step();
      rst = 1'b0;
      step();
      n_cmp++;
      if ({busy, done, err} !== 3'b000) begin
         n_bad++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, err});
      end
   endtask

   task automatic test_load3();
      logic [31:0] words [3];
      words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h44444444;
      start = 1; din_valid = 1; din = 32'd7;   // valid alongside start must be ignored
      step();
      start = 0;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL load3_busy: got %b want 1", busy); end
      din = 32'd3;
      step();
      n_cmp++;
      if (busy !== 1'b1 || imem_we !== 1'b0) begin
         n_bad++; $display("FAIL load3_len: busy=%b we=%b want 1 0", busy, imem_we);
      end
      for (int i = 0; i < 3; i++) begin
         din = words[i];
         step();
         n_cmp++;
         if (imem_we !== 1'b1 || imem_addr !== 14'(i) || imem_wdata !== words[i]) begin
            n_bad++; $display("FAIL load3_write%0d: we=%b addr=%h data=%h want 1 %h %h",
                              i, imem_we, imem_addr, imem_wdata, i, words[i]);
         end
         n_cmp++;
         if (done !== (i == 2) || ack_send !== (i == 2)) begin
            n_bad++; $display("FAIL load3_done%0d: done=%b ack_send=%b want %0d", i, done, ack_send, i == 2);
         end
      end
      n_cmp++;
      if (checksum !== 32'h77777777 || ack_byte !== 8'hAA) begin
         n_bad++; $display("FAIL load3_csum: csum=%h ack=%h want 77777777 aa", checksum, ack_byte);
      end
      din_valid = 0;
      step();
      n_cmp++;
      if (imem_we !== 1'b0 || ack_send !== 1'b0 || done !== 1'b1) begin
         n_bad++; $display("FAIL load3_after: we=%b ack_send=%b done=%b want 0 0 1", imem_we, ack_send, done);
      end
   endtask

   task automatic test_len_zero();
      int w0;
      start = 1; step(); start = 0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL len0_arm: done=%b busy=%b want 0 1", done, busy);
      end
      w0 = wr_cnt;
      din = 32'd0; din_valid = 1; step(); din_valid = 0;
      n_cmp++;
      if (done !== 1'b1 || ack_send !== 1'b1 || ack_byte !== 8'hAA || imem_we !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL len0: done=%b ack_send=%b ack=%h we=%b busy=%b want 1 1 aa 0 0",
                           done, ack_send, ack_byte, imem_we, busy);
      end
      step(); step();
      n_cmp++;
      if (wr_cnt != w0 || ack_send !== 1'b0) begin
         n_bad++; $display("FAIL len0_nowrite: writes=%0d ack_send=%b want 0 0", wr_cnt - w0, ack_send);
      end
   endtask

   task automatic test_oversize();
      int w0;
      w0 = wr_cnt;
      start = 1; step(); start = 0;
      din = 32'd16385; din_valid = 1; step(); din_valid = 0;
      n_cmp++;
      if (err !== 1'b1 || ack_send !== 1'b1 || ack_byte !== 8'h55 || done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL oversize: err=%b ack_send=%b ack=%h done=%b busy=%b want 1 1 55 0 0",
                           err, ack_send, ack_byte, done, busy);
      end
      // upper bits set while low bits look small
      start = 1; step(); start = 0;
      din = 32'h8000_0002; din_valid = 1; step(); din_valid = 0;
      n_cmp++;
      if (err !== 1'b1 || ack_send !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL oversize_hi: err=%b ack_send=%b busy=%b want 1 1 0", err, ack_send, busy);
      end
      step();
      n_cmp++;
      if (wr_cnt != w0) begin n_bad++; $display("FAIL oversize_nowrite: writes=%0d want 0", wr_cnt - w0); end
      start = 1; step(); start = 0;
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL oversize_clear: err=%b busy=%b want 0 1", err, busy);
      end
      din = 32'd1; din_valid = 1; step();
      din = 32'hDEADBEEF; step(); din_valid = 0;
      n_cmp++;
      if (imem_we !== 1'b1 || imem_addr !== 14'd0 || imem_wdata !== 32'hDEADBEEF || done !== 1'b1
          || checksum !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL oversize_reload: we=%b addr=%h data=%h done=%b csum=%h want 1 0 deadbeef 1 deadbeef",
                           imem_we, imem_addr, imem_wdata, done, checksum);
      end
   endtask

   task automatic test_spaced();
      int w0, we_seen;
      start = 1; step(); start = 0;
      din = 32'd2; din_valid = 1; step(); din_valid = 0;
      w0 = wr_cnt;
      for (int k = 0; k < 2; k++) begin
         we_seen = 0;
         for (int j = 0; j < 5; j++) begin
            start = (j == 2);
            step();
            if (imem_we === 1'b1) we_seen++;
         end
         start = 0;
         n_cmp++;
         if (we_seen != 0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL spaced_idle%0d: writes=%0d busy=%b want 0 1", k, we_seen, busy);
         end
         din = 32'hA000_0000 + 32'(k); din_valid = 1; step(); din_valid = 0;
         n_cmp++;
         if (imem_we !== 1'b1 || imem_addr !== 14'(k) || imem_wdata !== 32'hA000_0000 + 32'(k)) begin
            n_bad++; $display("FAIL spaced_write%0d: we=%b addr=%h data=%h want 1 %h %h",
                              k, imem_we, imem_addr, imem_wdata, k, 32'hA000_0000 + 32'(k));
         end
         step();
         n_cmp++;
         if (imem_we !== 1'b0) begin n_bad++; $display("FAIL spaced_pulse%0d: we=%b want 0", k, imem_we); end
      end
      n_cmp++;
      if (wr_cnt - w0 != 2 || done !== 1'b1 || checksum !== 32'h0000_0001) begin
         n_bad++; $display("FAIL spaced_total: writes=%0d done=%b csum=%h want 2 1 00000001",
                           wr_cnt - w0, done, checksum);
      end
   endtask

   task automatic test_reset_mid_load();
      int w0;
      start = 1; step(); start = 0;
      din = 32'd4; din_valid = 1; step();
      din = 32'h0000_00F0; step();
      din = 32'h0000_0F00; step();
      din_valid = 0;
      n_cmp++;
      if (imem_we !== 1'b1 || busy !== 1'b1 || checksum !== 32'h0000_0FF0) begin
         n_bad++; $display("FAIL midrst_pre: we=%b busy=%b csum=%h want 1 1 00000ff0", imem_we, busy, checksum);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({imem_we, busy, done, err, ack_send} !== 5'b0 || imem_addr !== '0 || imem_wdata !== '0
          || checksum !== '0 || ack_byte !== 8'h00) begin
         n_bad++; $display("FAIL midrst_async: flags=%b addr=%h data=%h csum=%h ack=%h want all 0",
                           {imem_we, busy, done, err, ack_send}, imem_addr, imem_wdata, checksum, ack_byte);
      end
      step(); step();
      rst = 1'b0;
      w0 = wr_cnt;
      din_valid = 1;
      for (int i = 0; i < 4; i++) begin din = 32'h55 + 32'(i); step(); end
      din_valid = 0;
      step();
      n_cmp++;
      if (wr_cnt != w0 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL midrst_idle: writes=%0d busy=%b done=%b want 0 0 0", wr_cnt - w0, busy, done);
      end
   endtask

   task automatic test_small_back_to_back();
      logic [31:0] exp_csum;
      int bad_wr;
      exp_csum = '0;
      bad_wr = 0;
      s_start = 1; step(); s_start = 0;
      s_din = 32'd16; s_din_valid = 1; step();
      for (int i = 0; i < 16; i++) begin
         s_din = 32'h1000 + 32'(i * 3);
         exp_csum ^= s_din;
         step();
         if (s_imem_we !== 1'b1 || s_imem_addr !== 4'(i) || s_imem_wdata !== 32'h1000 + 32'(i * 3)
             || s_done !== (i == 15)) begin
            bad_wr++;
            $display("FAIL small_write%0d: we=%b addr=%h data=%h done=%b", i, s_imem_we, s_imem_addr,
                     s_imem_wdata, s_done);
         end
      end
      n_cmp++;
      if (bad_wr != 0) begin n_bad++; $display("FAIL small_writes: bad=%0d want 0", bad_wr); end
      n_cmp++;
      if (s_checksum !== exp_csum || s_ack_send !== 1'b1 || s_ack_byte !== 8'hAA) begin
         n_bad++; $display("FAIL small_end: csum=%h ack_send=%b ack=%h want %h 1 aa",
                           s_checksum, s_ack_send, s_ack_byte, exp_csum);
      end
      s_din = 32'h2222; step(); s_din_valid = 0;
      n_cmp++;
      if (s_imem_we !== 1'b0 || s_done !== 1'b1) begin
         n_bad++; $display("FAIL small_nowrap: we=%b done=%b want 0 1", s_imem_we, s_done);
      end
      s_start = 1; step(); s_start = 0;
      s_din = 32'd17; s_din_valid = 1; step(); s_din_valid = 0;
      n_cmp++;
      if (s_err !== 1'b1 || s_ack_byte !== 8'h55 || s_ack_send !== 1'b1) begin
         n_bad++; $display("FAIL small_17: err=%b ack=%h ack_send=%b want 1 55 1", s_err, s_ack_byte, s_ack_send);
      end
   endtask

   initial begin
      test_reset();
      test_load3();
      test_len_zero();
      test_oversize();
      test_spaced();
      test_reset_mid_load();
      test_small_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
